// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: {bout, diff} = a - b - bin, one bit per clock, LSB first,
// behind a start/done handshake with back-to-back accept from the DONE state.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               bout_q, bout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // One full-subtractor cell, reused on every RUN cycle.
    logic diff_bit;
    logic borrow_next;
    assign diff_bit    = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
    assign borrow_next = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {diff_bit, res_sh_q[WIDTH-1:1]};
                borrow_d = borrow_next;
                if (cnt_q == LAST_BIT) begin
                    diff_d  = {diff_bit, res_sh_q[WIDTH-1:1]};
                    bout_d  = borrow_next;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are small flops, not a memory, so clearing them on reset is cheap and required.
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
        end
    end

    // Handshake outputs decode the state register alone, so they cannot glitch.
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, mid-run reset and a random sweep
// compared against a plain-arithmetic reference {1'b0,a} - {1'b0,b} - bin.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    int checks = 0;
    int errors = 0;

    // Reference view of the last completed result (what diff/bout must hold).
    logic [WIDTH-1:0] last_diff;
    logic             last_bout;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge while the DUT is in IDLE or DONE.
    task automatic start_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                            input logic op_bin);
        a     = op_a;
        b     = op_b;
        bin   = op_bin;
        start = 1'b1;
    endtask

    // Waits for the done pulse of the op started by start_op and checks latency and result.
    // Operands are scrambled and a stray start is pulsed mid-RUN; both must be ignored.
    task automatic wait_done(input string tag, input logic [WIDTH-1:0] op_a,
                             input logic [WIDTH-1:0] op_b, input logic op_bin);
        logic [WIDTH:0] ref_full;
        int n;
        int busy_n;
        bit got;
        ref_full = {1'b0, op_a} - {1'b0, op_b} - {{WIDTH{1'b0}}, op_bin};
        n = 0;
        busy_n = 0;
        got = 1'b0;
        while (!got && n < WIDTH + 6) begin
            tick();
            n++;
            if (n == 1) begin
                start = 1'b0;
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
                bin   = 1'($urandom);
            end
            if (n == 2) begin
                check({tag, "_hold_diff"}, 32'(diff), 32'(last_diff));
                check({tag, "_hold_bout"}, 32'(bout), 32'(last_bout));
            end
            if (n == 3) begin
                start = 1'b1;
                a     = '0;
            end
            if (n == 4) start = 1'b0;
            if (busy) busy_n++;
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(WIDTH + 1));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(WIDTH));
        check({tag, "_diff"}, 32'(diff), 32'(ref_full[WIDTH-1:0]));
        check({tag, "_bout"}, 32'(bout), 32'(ref_full[WIDTH]));
        last_diff = ref_full[WIDTH-1:0];
        last_bout = ref_full[WIDTH];
    endtask

    task automatic go_idle(input string tag);
        tick();
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_diff"}, 32'(diff), 32'(last_diff));
    endtask

    initial begin
        int done_seen;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        last_diff = '0;
        last_bout = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);

        // Directed cases from the block's own examples.
        start_op(8'd5, 8'd3, 1'b0);    wait_done("d5m3", 8'd5, 8'd3, 1'b0);
        check("d5m3_abs_diff", 32'(diff), 32'h02);
        go_idle("d5m3");
        start_op(8'd3, 8'd5, 1'b0);    wait_done("d3m5", 8'd3, 8'd5, 1'b0);
        check("d3m5_abs_diff", 32'(diff), 32'hFE);
        check("d3m5_abs_bout", 32'(bout), 32'd1);
        go_idle("d3m5");
        start_op(8'h00, 8'h00, 1'b1);  wait_done("d0m0b", 8'h00, 8'h00, 1'b1);
        check("d0m0b_abs_diff", 32'(diff), 32'hFF);
        go_idle("d0m0b");
        start_op(8'hFF, 8'hFF, 1'b0);  wait_done("dffmff", 8'hFF, 8'hFF, 1'b0);
        check("dffmff_abs_diff", 32'(diff), 32'h00);
        go_idle("dffmff");
        start_op(8'hA5, 8'h5A, 1'b0);  wait_done("da5m5a", 8'hA5, 8'h5A, 1'b0);
        check("da5m5a_abs_diff", 32'(diff), 32'h4B);

        // Back-to-back: start held during the DONE cycle is accepted with no dead cycle.
        start_op(8'd1, 8'd2, 1'b0);    wait_done("b2b", 8'd1, 8'd2, 1'b0);
        check("b2b_abs_diff", 32'(diff), 32'hFF);
        check("b2b_abs_bout", 32'(bout), 32'd1);
        go_idle("b2b");

        // Reset in the middle of RUN kills the op; no done pulse may follow.
        start_op(8'd9, 8'd4, 1'b0);
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_bout", 32'(bout), 32'd0);
        last_diff = '0;
        last_bout = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("mid_rst_no_done", 32'(done_seen), 32'd0);

        // Random sweep, mixing back-to-back starts and idle gaps.
        for (int i = 0; i < 1000; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rbin;
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rbin = 1'($urandom);
            if (i % 8 == 0) begin
                ra = (i % 16 == 0) ? '0 : '1;
                rb = (i % 16 == 0) ? '1 : '0;
            end
            if ($urandom_range(1, 0) == 1 && i != 0) go_idle("rnd");
            start_op(ra, rb, rbin);
            wait_done("rnd", ra, rb, rbin);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
